// File: rtl/hnf_link_pkg.sv
// Shared CHI link-layer definitions for the HN-F TX/RX link controllers:
// link state encoding, the CHI L-credit ceiling and the L-credit-return flit.
package hnf_link_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    ACT   = 2'b01,
    RUN   = 2'b10,
    DEACT = 2'b11
  } link_state_e;

  localparam int unsigned CHI_LCRD_MAX = 15;

  // Return flit is all-zero; wide enough for any channel, sliced by the user.
  localparam int unsigned LCRD_FLIT_W_MAX = 512;
  localparam logic [LCRD_FLIT_W_MAX-1:0] LCRD_RETURN_FLIT = '0;

endpackage

// File: rtl/hnf_txlink_ctrl_if.sv
// Bus bundle between the HN-F TX link controller and its environment:
// upstream FIFO pop side, CHI TX channel/link handshake, control and status.
interface hnf_txlink_ctrl_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned LCRD_MAX   = 15
);
  localparam int unsigned CW = $clog2(LCRD_MAX + 1);

  logic                  link_en;
  logic                  fifo_empty;
  logic [FLIT_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  txlinkactivereq;
  logic                  txlinkactiveack;
  logic                  tx_flitpend;
  logic                  tx_flitv;
  logic [FLIT_WIDTH-1:0] tx_flit;
  logic                  tx_lcrdv;
  logic                  link_idle;
  logic                  crd_ovf;
  logic [CW-1:0]         crd_cnt;

  modport master (
    input  link_en, fifo_empty, fifo_rd_data, txlinkactiveack, tx_lcrdv,
    output fifo_rd_en, txlinkactivereq, tx_flitpend, tx_flitv, tx_flit,
           link_idle, crd_ovf, crd_cnt
  );

  modport slave (
    output link_en, fifo_empty, fifo_rd_data, txlinkactiveack, tx_lcrdv,
    input  fifo_rd_en, txlinkactivereq, tx_flitpend, tx_flitv, tx_flit,
           link_idle, crd_ovf, crd_cnt
  );
endinterface

// File: rtl/hnf_lcrd_cnt.sv
// Saturating L-credit up/down counter, shared by the TX and RX link controllers.
// inc and dec together leave the count unchanged; inc at MAX holds the count
// and sets the sticky ovf flag (cleared only by rst). clr zeroes the count.
module hnf_lcrd_cnt
  import hnf_link_pkg::*;
#(
  parameter int unsigned MAX = CHI_LCRD_MAX,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);

  // Credit count with saturation and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count == W'(MAX)) ovf <= 1'b1;
      else                  count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hnf_txlink_ctrl.sv
// CHI link-layer TX controller downstream of the HN-F outbound flit FIFO.
// Runs the TX link activation FSM, holds L-credits and sends one flit per
// credit while in RUN. Optional build macro HNF_TXLINK_LCRD_RETURN_EN:
// credits still held in DEACT are returned as all-zero flits before STOP;
// without it they are discarded by the counter clear on entry to STOP.
module hnf_txlink_ctrl
  import hnf_link_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned LCRD_MAX   = CHI_LCRD_MAX
) (
  input  logic              clk,
  input  logic              rst,
  hnf_txlink_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(LCRD_MAX + 1);

  link_state_e           state, state_d;
  logic [CW-1:0]         cnt;
  logic                  pop, ret, inc, dec, clr;
  logic                  cnt_ovf, stop_err;
  logic                  req_q, flitv_q;
  logic [FLIT_WIDTH-1:0] flit_q;

  // A protocol flit needs RUN, a head entry and a credit; a return flit
  // spends a held credit during DEACT without touching the FIFO.
  assign pop = (state == RUN) && !bus.fifo_empty && (cnt != '0);
`ifdef HNF_TXLINK_LCRD_RETURN_EN
  assign ret = (state == DEACT) && (cnt != '0);
`else
  assign ret = 1'b0;
`endif

  // Credits seen in STOP are not counted; they only raise the error flag.
  assign inc = bus.tx_lcrdv && (state != STOP);
  assign dec = pop || ret;
  assign clr = (state_d == STOP) && (state != STOP);

  hnf_lcrd_cnt #(.MAX(LCRD_MAX), .W(CW)) u_lcrd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .count (cnt),
    .ovf   (cnt_ovf)
  );

  // Link state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOP;
    else     state <= state_d;
  end

  // Next-state logic; ACT always completes to RUN even if link_en drops.
  always_comb begin
    state_d = state;
    case (state)
      STOP:  if (bus.link_en && !bus.txlinkactiveack) state_d = ACT;
      ACT:   if (bus.txlinkactiveack)                 state_d = RUN;
      RUN:   if (!bus.link_en)                        state_d = DEACT;
`ifdef HNF_TXLINK_LCRD_RETURN_EN
      DEACT: if (cnt == '0 && !bus.txlinkactiveack)   state_d = STOP;
`else
      DEACT: if (!bus.txlinkactiveack)                state_d = STOP;
`endif
      default:                                        state_d = STOP;
    endcase
  end

  // Registered link request follows the decided next state; sticky STOP error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      req_q <= (state_d == ACT) || (state_d == RUN);
      if (bus.tx_lcrdv && state == STOP) stop_err <= 1'b1;
    end
  end

  // Flit output stage: one cycle after the pop/return; payload holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flitv_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      flitv_q <= pop || ret;
      if (pop)      flit_q <= bus.fifo_rd_data;
      else if (ret) flit_q <= LCRD_RETURN_FLIT[FLIT_WIDTH-1:0];
    end
  end

  assign bus.fifo_rd_en      = pop;
  assign bus.txlinkactivereq = req_q;
  assign bus.tx_flitpend     = (state == RUN) || (state == DEACT);
  assign bus.tx_flitv        = flitv_q;
  assign bus.tx_flit         = flit_q;
  assign bus.link_idle       = (state == STOP);
  assign bus.crd_ovf         = cnt_ovf || stop_err;
  assign bus.crd_cnt         = cnt;

endmodule

// File: tb/tb_hnf_txlink_ctrl.sv
// Directed bench for hnf_txlink_ctrl: activation, credit gating, grant+send
// in the same cycle, overflow, deactivation (both macro builds) and async reset.
module tb_hnf_txlink_ctrl;

  logic clk = 1'b0;
  logic rst;

  hnf_txlink_ctrl_if #(.FLIT_WIDTH(32), .LCRD_MAX(15)) bus ();

  hnf_txlink_ctrl #(.FLIT_WIDTH(32), .LCRD_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: bench pushes, DUT pops; emptied by rst.
  logic [31:0] mem [0:15];
  logic [4:0]  wr_ptr, rd_ptr;
  int          pop_total = 0;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data = mem[rd_ptr[3:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en) begin
      rd_ptr    <= rd_ptr + 5'd1;
      pop_total <= pop_total + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  logic [31:0] burst [0:7];
  int pops0;

  initial begin
    rst = 1'b1;
    wr_ptr = '0;
    bus.link_en = 1'b0;
    bus.txlinkactiveack = 1'b0;
    bus.tx_lcrdv = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req",   bus.txlinkactivereq, 0);
    chk("rst_flitv", bus.tx_flitv, 0);
    chk("rst_flit",  bus.tx_flit, 0);
    chk("rst_cnt",   bus.crd_cnt, 0);
    chk("rst_ovf",   bus.crd_ovf, 0);
    chk("rst_idle",  bus.link_idle, 1);
    chk("rst_pend",  bus.tx_flitpend, 0);
    rst = 1'b0;

    // Activation: STOP -> ACT, ack three cycles later -> RUN
    bus.link_en = 1'b1;
    tick();
    chk("act_req",  bus.txlinkactivereq, 1);
    chk("act_idle", bus.link_idle, 0);
    chk("act_pend", bus.tx_flitpend, 0);
    tick(); tick();
    chk("act_hold_req",   bus.txlinkactivereq, 1);
    chk("act_hold_flitv", bus.tx_flitv, 0);
    tick();
    bus.txlinkactiveack = 1'b1;
    tick();
    chk("run_pend",  bus.tx_flitpend, 1);
    chk("run_req",   bus.txlinkactivereq, 1);
    chk("run_flitv", bus.tx_flitv, 0);

    // Credit gating: four flits queued, no credits yet
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    #1;
    chk("gate_nocrd_rden", bus.fifo_rd_en, 0);
    bus.tx_lcrdv = 1'b1;
    tick();
    chk("gate_cnt1",  bus.crd_cnt, 1);
    chk("gate_rden",  bus.fifo_rd_en, 1);
    chk("gate_flitv0", bus.tx_flitv, 0);
    tick();
    bus.tx_lcrdv = 1'b0;
    chk("gate_a0_v",   bus.tx_flitv, 1);
    chk("gate_a0",     bus.tx_flit, 32'hA0);
    chk("gate_a0_cnt", bus.crd_cnt, 1);
    tick();
    chk("gate_a1_v",   bus.tx_flitv, 1);
    chk("gate_a1",     bus.tx_flit, 32'hA1);
    chk("gate_a1_cnt", bus.crd_cnt, 0);
    tick();
    chk("gate_stall_v",    bus.tx_flitv, 0);
    chk("gate_stall_hold", bus.tx_flit, 32'hA1);
    chk("gate_stall_rden", bus.fifo_rd_en, 0);
    bus.tx_lcrdv = 1'b1;
    tick();
    bus.tx_lcrdv = 1'b0;
    chk("gate_g3_v",   bus.tx_flitv, 0);
    chk("gate_g3_cnt", bus.crd_cnt, 1);
    tick();
    chk("gate_a2_v",   bus.tx_flitv, 1);
    chk("gate_a2",     bus.tx_flit, 32'hA2);
    chk("gate_a2_cnt", bus.crd_cnt, 0);

    // Simultaneous grant and send: A3 plus B0..B6 back to back
    burst[0] = 32'hA3;
    for (int i = 0; i < 7; i++) begin
      push(32'hB0 + 32'(i));
      burst[i+1] = 32'hB0 + 32'(i);
    end
    bus.tx_lcrdv = 1'b1;
    tick();
    chk("sim_cnt1",  bus.crd_cnt, 1);
    chk("sim_flitv", bus.tx_flitv, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sim_v",    bus.tx_flitv, 1);
      chk("sim_flit", bus.tx_flit, burst[i]);
      chk("sim_cnt",  bus.crd_cnt, 1);
    end
    bus.tx_lcrdv = 1'b0;
    tick();
    chk("sim_end_v",   bus.tx_flitv, 0);
    chk("sim_end_cnt", bus.crd_cnt, 1);

    // Overflow: 16 grants with nothing to send, starting from 1 held
    chk("ovf_pre", bus.crd_ovf, 0);
    bus.tx_lcrdv = 1'b1;
    repeat (14) tick();
    chk("ovf_full_cnt", bus.crd_cnt, 15);
    chk("ovf_full_ovf", bus.crd_ovf, 0);
    tick();
    chk("ovf_sat_cnt", bus.crd_cnt, 15);
    chk("ovf_set",     bus.crd_ovf, 1);
    tick();
    bus.tx_lcrdv = 1'b0;
    tick();
    chk("ovf_sticky", bus.crd_ovf, 1);
    chk("ovf_cnt",    bus.crd_cnt, 15);

    // Spend 12 credits to leave 3 held
    for (int i = 0; i < 12; i++) push(32'hC0 + 32'(i));
    repeat (12) tick();
    chk("drain_last", bus.tx_flit, 32'hCB);
    tick();
    chk("drain_cnt",   bus.crd_cnt, 3);
    chk("drain_flitv", bus.tx_flitv, 0);

    // Deactivation with 3 credits held
    pops0 = pop_total;
    bus.link_en = 1'b0;
    tick();
    chk("deact_req",  bus.txlinkactivereq, 0);
    chk("deact_pend", bus.tx_flitpend, 1);
    chk("deact_idle", bus.link_idle, 0);
`ifdef HNF_TXLINK_LCRD_RETURN_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ret_v",    bus.tx_flitv, 1);
      chk("ret_flit", bus.tx_flit, 0);
      chk("ret_cnt",  bus.crd_cnt, 32'(2 - i));
    end
    bus.txlinkactiveack = 1'b0;
    tick();
    chk("stop_idle",  bus.link_idle, 1);
    chk("stop_flitv", bus.tx_flitv, 0);
    chk("stop_cnt",   bus.crd_cnt, 0);
`else
    tick();
    chk("deact_noflit", bus.tx_flitv, 0);
    chk("deact_cnt",    bus.crd_cnt, 3);
    chk("deact_wait",   bus.link_idle, 0);
    bus.txlinkactiveack = 1'b0;
    tick();
    chk("stop_idle",  bus.link_idle, 1);
    chk("stop_cnt",   bus.crd_cnt, 0);
    chk("stop_flitv", bus.tx_flitv, 0);
    chk("stop_pend",  bus.tx_flitpend, 0);
`endif
    chk("deact_nopop", 32'(pop_total - pops0), 0);
    chk("stop_ovf",    bus.crd_ovf, 1);

    // Async reset mid-burst in RUN
    for (int i = 0; i < 6; i++) push(32'hD0 + 32'(i));
    bus.link_en = 1'b1;
    tick();
    bus.txlinkactiveack = 1'b1;
    tick();
    chk("re_run_req", bus.txlinkactivereq, 1);
    bus.tx_lcrdv = 1'b1;
    tick(); tick(); tick();
    chk("burst_v",  bus.tx_flitv, 1);
    chk("burst_d1", bus.tx_flit, 32'hD1);
    #2 rst = 1'b1;
    #1;
    chk("arst_flitv", bus.tx_flitv, 0);
    chk("arst_req",   bus.txlinkactivereq, 0);
    chk("arst_cnt",   bus.crd_cnt, 0);
    chk("arst_idle",  bus.link_idle, 1);
    chk("arst_rden",  bus.fifo_rd_en, 0);
    tick();
    chk("arst_e_flitv", bus.tx_flitv, 0);
    chk("arst_e_req",   bus.txlinkactivereq, 0);
    chk("arst_e_cnt",   bus.crd_cnt, 0);
    chk("arst_e_idle",  bus.link_idle, 1);
    chk("arst_e_rden",  bus.fifo_rd_en, 0);
    chk("arst_e_ovf",   bus.crd_ovf, 0);
    bus.link_en = 1'b0;
    bus.txlinkactiveack = 1'b0;
    bus.tx_lcrdv = 1'b0;
    tick();
    rst = 1'b0;

    // Credit in STOP: ignored, raises the sticky error
    bus.tx_lcrdv = 1'b1;
    tick();
    bus.tx_lcrdv = 1'b0;
    tick();
    chk("stopcrd_cnt",  bus.crd_cnt, 0);
    chk("stopcrd_ovf",  bus.crd_ovf, 1);
    chk("stopcrd_idle", bus.link_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hnf_txlink_ctrl.md
# hnf_txlink_ctrl

CHI link-layer transmit controller sitting directly downstream of the HN-F outbound flit FIFO. Pops flits from the FIFO and drives them onto one outbound CHI channel (TXREQ/TXRSP/TXSNP/TXDAT instance). Sends only when the link is in RUN and a link-layer credit (L-credit) is held. Owns the TX link activation state machine and the L-credit counter.

## Interface
- FLIT_WIDTH, 32, flit width; equals the upstream FIFO entry width.
- LCRD_MAX, 15, maximum L-credits held; CHI limit is 15.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- link_en  in  1  request link up (1) / link down (0) from HN-F control
- fifo_empty  in  1  upstream FIFO empty
- fifo_rd_data  in  FLIT_WIDTH  upstream FIFO head entry
- fifo_rd_en  out  FLIT_WIDTH-independent 1  pop strobe to FIFO, combinational
- txlinkactivereq  out  1  CHI TX link activate request, registered
- txlinkactiveack  in  1  CHI TX link activate acknowledge from receiver
- tx_flitpend  out  1  CHI flit pending
- tx_flitv  out  1  flit valid, registered
- tx_flit  out  FLIT_WIDTH  flit payload, registered
- tx_lcrdv  in  1  L-credit grant from receiver, one credit per cycle high
- link_idle  out  1  state == STOP
- crd_ovf  out  1  sticky error: credit received with counter at LCRD_MAX, or received in STOP
- crd_cnt  out  $clog2(LCRD_MAX+1)  debug: credits currently held

## Operation
- States:
  - STOP: req=0. To ACT when link_en=1 and ack=0.
  - ACT: req=1. To RUN when ack=1.
  - RUN: req=1. To DEACT when link_en=0.
  - DEACT: req=0. Exit condition defined under Configuration.
- Send condition: fifo_rd_en = (state==RUN) & ~fifo_empty & (crd_cnt!=0). Never pop an empty FIFO.
- On a pop, capture fifo_rd_data into tx_flit; tx_flitv=1 the next cycle. Otherwise tx_flitv=0. tx_flit holds its last value.
- tx_flitpend = 1 in RUN and DEACT, 0 otherwise.
- Credit counter:
  - +1 on tx_lcrdv.
  - −1 on each flit sent (protocol or credit-return).
  - Both in the same cycle: unchanged.
  - Saturates at LCRD_MAX and sets crd_ovf.
  - tx_lcrdv in STOP is ignored and sets crd_ovf.
  - Cleared to 0 on entry to STOP.
- crd_ovf is cleared only by rst.
- link_en toggling in ACT does not abort: the block completes ACT→RUN, then goes to DEACT if link_en=0.

## Timing
- Reset values: all outputs 0, including txlinkactivereq, tx_flitv, tx_flit, crd_cnt, crd_ovf. link_idle=1. State=STOP.
- rst mid-operation: immediate return to reset values. Any in-flight flit is dropped; the FIFO is reset by the same rst.
- Latency: pop in cycle N gives tx_flitv in N+1.
- Credit received in cycle N is usable for a pop in N+1.
- Throughput: one flit per cycle while credits ≥1 and the FIFO is non-empty.
- With 1 credit and no returns: one flit, then stall until tx_lcrdv.
- txlinkactivereq changes one cycle after the state transition is decided.
- tx_flitpend rises at least one cycle before the first tx_flitv.

## Configuration
- HNF_TXLINK_LCRD_RETURN_EN defined:
  - In DEACT, while crd_cnt!=0, send one L-credit-return flit per cycle: tx_flitv=1, tx_flit all-zero, counter −1, no FIFO pop.
  - DEACT→STOP when crd_cnt==0 and txlinkactiveack==0.
- Macro undefined:
  - No return flits are sent.
  - DEACT→STOP when txlinkactiveack==0; held credits are discarded by the clear on entry to STOP.

## Structure
- Shared package hnf_link_pkg holds:
  - state encoding STOP=2'b00, ACT=2'b01, RUN=2'b10, DEACT=2'b11;
  - CHI_LCRD_MAX=15;
  - the L-credit-return flit constant (all-zero).
- One sub-module, hnf_lcrd_cnt: a saturating up/down counter with inc, dec, clr, count and ovf ports. The same sub-module is reused by the RX link controller.

## Test plan
- Activation: link_en=1, ack rises 3 cycles after req → STOP→ACT→RUN, req=1, link_idle=0, tx_flitpend=1, no flitv before RUN.
- Credit gating: RUN, FIFO holds 4 flits (0xA0..0xA3), grant 2 credits → exactly 2 flits (0xA0, 0xA1) sent, each one cycle after its pop. Then grant 1 more → 0xA2 sent next cycle, crd_cnt=0.
- Simultaneous grant and send: crd_cnt=1, tx_lcrdv=1 every cycle, FIFO pre-filled with 8 flits → 8 back-to-back flits, crd_cnt stays 1.
- Overflow: grant 16 credits with no sends → crd_cnt=15, crd_ovf=1 and stays 1 until rst.
- Deactivation with 3 credits held:
  - with HNF_TXLINK_LCRD_RETURN_EN: 3 all-zero flits, no FIFO pops, STOP after ack=0;
  - without it: no flits, STOP on ack=0, crd_cnt=0.
- Async reset in RUN mid-burst → next edge shows tx_flitv=0, req=0, crd_cnt=0, link_idle=1, and no fifo_rd_en.
